// File: rtl/gb_instr_sequencer.sv
// gb_instr_sequencer: programmable source of instruction/valid beats.
// Supports increment, decrement, 16-bit Fibonacci LFSR and constant modes,
// a programmable beat count, abort, and backpressure from the consumer.
// All outputs are registered; the FSM is split into a state/data register
// process and a combinational next-state process.
module gb_instr_sequencer #(
  parameter int          INSTR_WIDTH = 8,
  parameter int          COUNT_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [INSTR_WIDTH-1:0] start_value,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   valid,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] issued
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_DEC   = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  state_t                 state;
  state_t                 state_next;
  logic [1:0]             mode_q;
  logic [1:0]             mode_next;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [COUNT_WIDTH-1:0] remaining_next;
  logic [COUNT_WIDTH-1:0] issued_next;
  logic [15:0]            lfsr;
  logic [15:0]            lfsr_next;
  logic [15:0]            lfsr_adv;
  logic [INSTR_WIDTH-1:0] instr_next;
  logic                   transfer;

  // One Fibonacci step: taps 0,2,3,5, feedback shifted in at the top.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Next-state, next-value and beat bookkeeping; abort outranks a transfer.
  always_comb begin
    state_next     = state;
    mode_next      = mode_q;
    remaining_next = remaining;
    issued_next    = issued;
    lfsr_next      = lfsr;
    instr_next     = instruction;
    lfsr_adv       = lfsr_step(lfsr);
    transfer       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          issued_next = '0;
          if (count != '0) begin
            mode_next      = mode;
            remaining_next = count;
            lfsr_next      = LFSR_SEED;
            if (mode == MODE_LFSR) begin
              instr_next = LFSR_SEED[INSTR_WIDTH-1:0];
            end else begin
              instr_next = start_value;
            end
            state_next = RUN;
          end else begin
            state_next = DONE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (valid && ready) begin
          transfer       = 1'b1;
          remaining_next = remaining - COUNT_WIDTH'(1);
          issued_next    = issued + COUNT_WIDTH'(1);
          case (mode_q)
            MODE_INC:   instr_next = instruction + INSTR_WIDTH'(1);
            MODE_DEC:   instr_next = instruction - INSTR_WIDTH'(1);
            MODE_LFSR: begin
              lfsr_next  = lfsr_adv;
              instr_next = lfsr_adv[INSTR_WIDTH-1:0];
            end
            MODE_CONST: instr_next = instruction;
            default:    instr_next = instruction;
          endcase
          if (remaining == COUNT_WIDTH'(1)) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, data and registered outputs; outputs reflect the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= MODE_INC;
      remaining   <= '0;
      issued      <= '0;
      lfsr        <= LFSR_SEED;
      instruction <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      mode_q      <= mode_next;
      remaining   <= remaining_next;
      issued      <= issued_next;
      lfsr        <= lfsr_next;
      instruction <= instr_next;
      valid       <= (state_next == RUN);
      busy        <= (state_next != IDLE);
      done        <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_gb_instr_sequencer.sv
// Directed bench for gb_instr_sequencer with a beat scoreboard.
module tb_gb_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [7:0]  start_value;
  logic [15:0] count;
  logic        ready;
  logic [7:0]  instruction;
  logic        valid;
  logic        busy;
  logic        done;
  logic [15:0] issued;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];
  int cyc = 0;
  int done_cnt = 0;
  int last_beat_cyc = -1;
  int beats = 0;
  int snap;

  gb_instr_sequencer #(.INSTR_WIDTH(8), .COUNT_WIDTH(16), .LFSR_SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .start_value(start_value), .count(count), .ready(ready),
    .instruction(instruction), .valid(valid), .busy(busy), .done(done), .issued(issued)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Cycle counter for latency checks.
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every accepted beat must match the head of the expected queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (valid && ready && !abort) begin
        beats++;
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          $error("FAIL unexpected_beat: observed 0x%0h expected no beat", instruction);
        end else begin
          chk("beat", {24'h0, instruction}, {24'h0, exp_q.pop_front()});
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_model(input logic [1:0] m, input logic [7:0] sv, input int n);
    logic [7:0] v;
    v = sv;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      if (m == 2'd0) v = v + 8'd1;
      else if (m == 2'd1) v = v - 8'd1;
      else v = v;
    end
  endtask

  task automatic launch(input logic [1:0] m, input logic [7:0] sv, input logic [15:0] n);
    mode = m;
    start_value = sv;
    count = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = ~m;
    start_value = ~sv;
    count = 16'd7;
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done) break;
      tick();
    end
    chk({tag, "_done_seen"}, {31'h0, done}, 32'd1);
  endtask

  task automatic finish_seq(input string tag, input int n);
    chk({tag, "_valid_off"}, {31'h0, valid}, 32'd0);
    chk({tag, "_issued"}, {16'h0, issued}, n);
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, {31'h0, done}, 32'd0);
    chk({tag, "_idle"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
    start_value = 8'h00; count = 16'd0; ready = 1'b1;
    tick();
    tick();
    chk("rst_instruction", {24'h0, instruction}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_issued", {16'h0, issued}, 32'd0);
    reset = 1'b0;
    tick();

    // Full sweep 0x00..0xFF.
    push_model(2'd0, 8'h00, 256);
    beats = 0;
    launch(2'd0, 8'h00, 16'd256);
    chk("sweep_first_valid", {31'h0, valid}, 32'd1);
    chk("sweep_first_instr", {24'h0, instruction}, 32'h00);
    chk("sweep_busy", {31'h0, busy}, 32'd1);
    wait_done("sweep", 300);
    chk("sweep_done_after_last", cyc, last_beat_cyc + 1);
    chk("sweep_beats", beats, 32'd256);
    finish_seq("sweep", 256);

    // Wrap, then restart in the first IDLE cycle after DONE.
    push_model(2'd0, 8'hFE, 4);
    launch(2'd0, 8'hFE, 16'd4);
    wait_done("wrap", 20);
    finish_seq("wrap", 4);

    push_model(2'd1, 8'h01, 3);
    launch(2'd1, 8'h01, 16'd3);
    wait_done("dec", 20);
    finish_seq("dec", 3);

    // Backpressure: stall cycles 2-4 of RUN.
    push_model(2'd0, 8'h10, 3);
    launch(2'd0, 8'h10, 16'd3);
    chk("bp_first", {24'h0, instruction}, 32'h10);
    tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", {31'h0, valid}, 32'd1);
      chk("bp_hold_instr", {24'h0, instruction}, 32'h11);
      chk("bp_hold_issued", {16'h0, issued}, 32'd1);
      tick();
    end
    ready = 1'b1;
    wait_done("bp", 20);
    finish_seq("bp", 3);

    // LFSR mode from the default seed.
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'h70);
    exp_q.push_back(8'h38);
    launch(2'd2, 8'h55, 16'd3);
    wait_done("lfsr", 20);
    finish_seq("lfsr", 3);

    // Constant mode, ignored restart, abort after 4 transfers.
    push_model(2'd3, 8'h3C, 4);
    snap = done_cnt;
    launch(2'd3, 8'h3C, 16'd10);
    start = 1'b1;
    mode = 2'd0;
    start_value = 8'h99;
    tick();
    start = 1'b0;
    chk("abort_restart_ignored", {24'h0, instruction}, 32'h3C);
    tick();
    tick();
    tick();
    chk("abort_pre_issued", {16'h0, issued}, 32'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", {31'h0, valid}, 32'd0);
    chk("abort_issued", {16'h0, issued}, 32'd4);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    tick();
    tick();
    chk("abort_no_done", done_cnt, snap);
    chk("abort_queue_empty", exp_q.size(), 32'd0);

    // count = 0: done pulse with no beat.
    beats = 0;
    launch(2'd0, 8'h05, 16'd0);
    chk("zero_done", {31'h0, done}, 32'd1);
    chk("zero_valid", {31'h0, valid}, 32'd0);
    chk("zero_issued", {16'h0, issued}, 32'd0);
    tick();
    chk("zero_done_once", {31'h0, done}, 32'd0);
    chk("zero_no_beats", beats, 32'd0);

    // Reset mid-RUN.
    push_model(2'd0, 8'h20, 10);
    launch(2'd0, 8'h20, 16'd10);
    tick();
    tick();
    snap = done_cnt;
    reset = 1'b1;
    tick();
    chk("midrst_instruction", {24'h0, instruction}, 32'h0);
    chk("midrst_valid", {31'h0, valid}, 32'd0);
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_done", {31'h0, done}, 32'd0);
    chk("midrst_issued", {16'h0, issued}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    tick();
    tick();
    tick();
    chk("midrst_no_done", done_cnt, snap);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
